alu_seq_mul: RTL and testbench

- Execute-stage ALU that consumes the 3-bit ALU control code produced by the ALU control decoder. Its result feeds the writeback mux.
- add, sub, and, or complete in one cycle.
- mul (code 3'b111) runs on an iterative shift-add multiplier over several cycles.
- A start/busy/done handshake lets the CPU control unit stall the PC while a multiply is in flight.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_shift_add_mul.sv | 58 +++++
 rtl/alu_seq_mul.sv | 89 ++++++++
 tb/tb_alu_seq_mul.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control codes, FSM states,
// default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH_DEF = 32;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per step, low WIDTH
// bits only. Define ALU_MUL_EARLY_EXIT_EN to finish as soon as the remaining
// multiplier bits are all zero.
module alu_shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] product_o,
  output logic             last_o
);

  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_acc_nxt, w_mplier_nxt;

  // Accumulator value after the current step; this is the product on the last step.
  always_comb begin
    w_acc_nxt    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_mplier_nxt = r_mplier >> 1;
  end

  assign product_o = w_acc_nxt;

`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last_o = (r_cnt == CNT_W'(WIDTH-1)) || (w_mplier_nxt == '0);
`else
  assign last_o = (r_cnt == CNT_W'(WIDTH-1));
`endif

  // Operand load on accept, then one shift-add iteration per step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (load_i) begin
      r_acc    <= '0;
      r_mcand  <= a_i;
      r_mplier <= b_i;
      r_cnt    <= '0;
    end else if (step_i) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_mul.sv
// Execute-stage ALU: add/sub/and/or in one cycle, multiply via the iterative
// shift-add unit with a start/busy/done handshake for PC stalling.
// Optional macro ALU_MUL_EARLY_EXIT_EN shortens multiplies (same results).
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);

  alu_state_e       r_state;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_alu, w_prod;
  logic             w_accept, w_load, w_step, w_last;

  // Start is only honoured outside an active multiply.
  assign w_accept = start_i && (r_state != ST_MUL);
  assign w_load   = w_accept && (ALUCtrl_i == ALU_MUL);
  assign w_step   = (r_state == ST_MUL);

  // Single-cycle operation mux; unknown codes give zero.
  always_comb begin
    w_alu = '0;
    case (ALUCtrl_i)
      ALU_ADD: w_alu = data1_i + data2_i;
      ALU_SUB: w_alu = data1_i - data2_i;
      ALU_AND: w_alu = data1_i & data2_i;
      ALU_OR:  w_alu = data1_i | data2_i;
      default: w_alu = '0;
    endcase
  end

  alu_shift_add_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (w_load),
    .step_i    (w_step),
    .a_i       (data1_i),
    .b_i       (data2_i),
    .product_o (w_prod),
    .last_o    (w_last)
  );

  // Control FSM; the result register only changes on entry to DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_MUL: begin
          if (w_last) begin
            r_data  <= w_prod;
            r_state <= ST_DONE;
          end
        end
        default: begin
          if (w_accept) begin
            if (ALUCtrl_i == ALU_MUL) begin
              r_state <= ST_MUL;
            end else begin
              r_data  <= w_alu;
              r_state <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign data_o = r_data;
  assign zero_o = (r_data == '0);
  assign busy_o = (r_state == ST_MUL);
  assign done_o = (r_state == ST_DONE);

endmodule

// File: tb/tb_alu_seq_mul.sv
// Directed bench for alu_seq_mul. Inputs change on the falling edge, outputs
// are sampled on the falling edge one cycle later.
module tb_alu_seq_mul;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] data1_i, data2_i;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data_o;
  logic        zero_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

`ifdef ALU_MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  alu_seq_mul #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data_o    (data_o),
    .zero_o    (zero_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
  endtask

  // Start a multiply, count cycles to done, optionally pulse start mid-run.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_val, input int exp_lat, input bit pulse);
    int k;
    int busy_cnt;
    bit seen;
    issue(3'b111, a, b);
    busy_cnt = 0;
    seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o) begin
        k = i;
        seen = 1'b1;
        break;
      end
      if (busy_o) busy_cnt++;
      if (pulse && i == 2) begin
        issue(3'b010, 32'h1, 32'h1);
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat - 1));
    chk({tag, "_data"}, data_o, exp_val);
    chk({tag, "_zero"}, 32'(zero_o), 32'(exp_val == 32'd0));
    start_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_idle"}, {30'd0, busy_o, done_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] b_rst;
    int cyc;
    int done_hits;

    rst_i = 1'b1; start_i = 1'b0; ALUCtrl_i = 3'b000; data1_i = '0; data2_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_data", data_o, 32'h0);
    chk("rst_zero", 32'(zero_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    // add then sub, back to back
    issue(3'b010, 32'h7FFF_FFFF, 32'h1);
    @(negedge clk_i);
    chk("add_data", data_o, 32'h8000_0000);
    chk("add_done", 32'(done_o), 32'd1);
    chk("add_zero", 32'(zero_o), 32'd0);
    issue(3'b110, 32'd5, 32'd5);
    @(negedge clk_i);
    chk("sub_data", data_o, 32'h0);
    chk("sub_zero", 32'(zero_o), 32'd1);
    chk("sub_done", 32'(done_o), 32'd1);

    // and then or on consecutive cycles
    issue(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    @(negedge clk_i);
    chk("and_data", data_o, 32'hF000_F000);
    chk("and_done", 32'(done_o), 32'd1);
    issue(3'b001, 32'h1, 32'h2);
    @(negedge clk_i);
    chk("or_data", data_o, 32'h3);
    chk("or_done", 32'(done_o), 32'd1);
    start_i = 1'b0;
    data1_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    chk("hold_done", 32'(done_o), 32'd0);
    chk("hold_data", data_o, 32'h3);

    // sub wrap and an undefined code
    issue(3'b110, 32'd0, 32'd1);
    @(negedge clk_i);
    chk("subwrap_data", data_o, 32'hFFFF_FFFF);
    issue(3'b011, 32'h1234, 32'h5678);
    @(negedge clk_i);
    chk("badop_data", data_o, 32'h0);
    chk("badop_zero", 32'(zero_o), 32'd1);
    start_i = 1'b0;
    @(negedge clk_i);

    // multiplies
    run_mul("mul_m1x3", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, EE ? 3 : 33, 1'b1);
    run_mul("mul_x0", 32'd12345, 32'd0, 32'h0, EE ? 2 : 33, 1'b0);
    run_mul("mul_gen", 32'h1234, 32'h5678, 32'h0626_0060, EE ? 16 : 33, 1'b0);

    // reset during the 10th multiply cycle; preload a nonzero result first
    issue(3'b001, 32'hAA, 32'h0);
    @(negedge clk_i);
    chk("pre_data", data_o, 32'hAA);
    b_rst = EE ? 32'h8000_0009 : 32'd9;
    issue(3'b111, 32'd7, b_rst);
    done_hits = 0;
    for (cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o) done_hits++;
    end
    chk("rstmul_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rstmul_busy", 32'(busy_o), 32'd0);
    chk("rstmul_data", data_o, 32'h0);
    chk("rstmul_zero", 32'(zero_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (done_o) done_hits++;
      @(negedge clk_i);
    end
    chk("rstmul_nodone", 32'(done_hits), 32'd0);
    issue(3'b010, 32'd2, 32'd3);
    @(negedge clk_i);
    chk("post_add_data", data_o, 32'd5);
    chk("post_add_done", 32'(done_o), 32'd1);
    start_i = 1'b0;
    @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
